// File: rtl/rat_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rat_pkg : shared types and reset value for the rename map table
// Rev 1.0
// ---------------------------------------------------------------------------
package rat_pkg;

  localparam int RAT_PREG_NUM = 64;
  localparam int RAT_PW       = $clog2(RAT_PREG_NUM);
  localparam int RAT_CKPT_NUM = 4;
  localparam int RAT_CKW      = $clog2(RAT_CKPT_NUM);
  localparam int RAT_LREG_NUM = 32;

  typedef logic [RAT_PW-1:0]                  preg_t;
  typedef logic [RAT_CKW-1:0]                 ckpt_id_t;
  typedef preg_t [RAT_LREG_NUM-1:0]           rat_t;

  // Identity map: logical r -> physical r
  function automatic rat_t rat_reset_value();
    rat_t v;
    for (int r = 0; r < RAT_LREG_NUM; r++) begin
      v[r] = preg_t'(r);
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rat_ckpt_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rat_ckpt_queue : circular queue of map-table snapshots for branches
// Rev 1.0
// ---------------------------------------------------------------------------
module rat_ckpt_queue
  import rat_pkg::*;
#(
  parameter int CKPT_NUM = RAT_CKPT_NUM,
  parameter int CKW      = $clog2(CKPT_NUM)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           alloc_i,
  input  rat_t           alloc_rat_i,
  input  logic           free_i,
  input  logic           truncate_i,
  input  logic [CKW-1:0] truncate_id_i,
  input  logic           clear_i,
  input  logic [CKW-1:0] read_id_i,
  output rat_t           read_rat_o,
  output logic           full_o,
  output logic           empty_o,
  output logic [CKW-1:0] tail_id_o
);

  logic [CKW:0]   r_head;
  logic [CKW:0]   r_tail;
  logic [CKW:0]   w_head_n;
  logic [CKW-1:0] w_dist;
  logic           w_free;
  rat_t           r_snap [CKPT_NUM];

  assign empty_o    = (r_head == r_tail);
  assign full_o     = (r_head[CKW] != r_tail[CKW]) && (r_head[CKW-1:0] == r_tail[CKW-1:0]);
  assign tail_id_o  = r_tail[CKW-1:0];
  assign read_rat_o = r_snap[read_id_i];

  assign w_free   = free_i && !empty_o;
  assign w_head_n = w_free ? r_head + (CKW+1)'(1) : r_head;
  // Distance of the restored slot from head; rebuilds the wrap bit of tail
  assign w_dist   = truncate_id_i - r_head[CKW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      for (int k = 0; k < CKPT_NUM; k++) begin
        r_snap[k] <= rat_reset_value();
      end
    end else begin
      if (clear_i) begin
        r_tail <= r_head;
      end else begin
        r_head <= w_head_n;
        if (truncate_i) begin
          r_tail <= (w_free && w_dist == '0) ? w_head_n : r_head + {1'b0, w_dist};
        end else if (alloc_i) begin
          r_tail <= r_tail + (CKW+1)'(1);
        end
      end
      if (alloc_i && !clear_i && !truncate_i) begin
        r_snap[r_tail[CKW-1:0]] <= alloc_rat_i;
      end
    end
  end

  a_no_free_when_empty: assert property (@(posedge clk) disable iff (!rst_n) !(free_i && empty_o));

endmodule
`default_nettype wire

// File: rtl/rename_map_table.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rename_map_table : speculative RAT with branch checkpoints and arch shadow
// Rev 1.0
// ---------------------------------------------------------------------------
module rename_map_table
  import rat_pkg::*;
#(
  parameter int PHY_REG_NUM  = RAT_PREG_NUM,
  parameter int RENAME_WIDTH = 2,
  parameter int COMMIT_WIDTH = 2,
  parameter int CKPT_NUM     = RAT_CKPT_NUM,
  parameter int PW           = $clog2(PHY_REG_NUM),
  parameter int CKW          = $clog2(CKPT_NUM)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [RENAME_WIDTH-1:0]          rename_valid_i,
  input  logic [RENAME_WIDTH-1:0][4:0]     src0_i,
  input  logic [RENAME_WIDTH-1:0][4:0]     src1_i,
  input  logic [RENAME_WIDTH-1:0]          dest_valid_i,
  input  logic [RENAME_WIDTH-1:0][4:0]     dest_i,
  input  logic [RENAME_WIDTH-1:0][PW-1:0]  preg_i,
  input  logic [RENAME_WIDTH-1:0]          ckpt_req_i,
  output logic                             ready_o,
  output logic [RENAME_WIDTH-1:0][PW-1:0]  psrc0_o,
  output logic [RENAME_WIDTH-1:0][PW-1:0]  psrc1_o,
  output logic [RENAME_WIDTH-1:0][PW-1:0]  ppdst_o,
  output logic [CKW-1:0]                   ckpt_id_o,
  input  logic                             ckpt_free_i,
  input  logic                             restore_i,
  input  logic [CKW-1:0]                   restore_id_i,
  input  logic [COMMIT_WIDTH-1:0]          commit_valid_i,
  input  logic [COMMIT_WIDTH-1:0][4:0]     commit_dest_i,
  input  logic [COMMIT_WIDTH-1:0][PW-1:0]  commit_preg_i,
  input  logic                             flush_i,
  output logic [31:0][PW-1:0]              arch_rat_o
);

  rat_t r_spec;
  rat_t r_arch;
  rat_t w_arch_n;
  rat_t w_snap_rat;
  rat_t w_restore_rat;
  rat_t w_stage [RENAME_WIDTH+1];
  logic w_full;
  logic w_empty;
  logic w_ready;
  logic w_alloc;

  assign w_ready    = !((|ckpt_req_i) && w_full) && !restore_i && !flush_i;
  assign w_alloc    = w_ready && (|ckpt_req_i);
  assign ready_o    = w_ready;
  assign arch_rat_o = r_arch;

  // Source/old-dest lookup with bypass from older instructions in the group.
  // r0 is never written, so the table entry for r0 stays 0.
  always_comb begin
    psrc0_o = '0;
    psrc1_o = '0;
    ppdst_o = '0;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      psrc0_o[i] = r_spec[src0_i[i]];
      psrc1_o[i] = r_spec[src1_i[i]];
      ppdst_o[i] = r_spec[dest_i[i]];
      for (int j = 0; j < RENAME_WIDTH; j++) begin
        if (j < i && dest_valid_i[j] && dest_i[j] != 5'd0) begin
          if (dest_i[j] == src0_i[i]) psrc0_o[i] = preg_i[j];
          if (dest_i[j] == src1_i[i]) psrc1_o[i] = preg_i[j];
          if (dest_i[j] == dest_i[i]) ppdst_o[i] = preg_i[j];
        end
      end
    end
  end

  // Stage k+1 holds the map with instructions 0..k applied (WAW: later wins)
  always_comb begin
    w_stage[0] = r_spec;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      w_stage[i+1] = w_stage[i];
      if (rename_valid_i[i] && dest_valid_i[i] && dest_i[i] != 5'd0) begin
        w_stage[i+1][dest_i[i]] = preg_i[i];
      end
    end
    w_snap_rat = w_stage[RENAME_WIDTH];
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      if (ckpt_req_i[k]) w_snap_rat = w_stage[k+1];
    end
  end

  always_comb begin
    w_arch_n = r_arch;
    for (int c = 0; c < COMMIT_WIDTH; c++) begin
      if (commit_valid_i[c] && commit_dest_i[c] != 5'd0) begin
        w_arch_n[commit_dest_i[c]] = commit_preg_i[c];
      end
    end
  end

  rat_ckpt_queue #(
    .CKPT_NUM (CKPT_NUM),
    .CKW      (CKW)
  ) u_ckpt_queue (
    .clk           (clk),
    .rst_n         (rst_n),
    .alloc_i       (w_alloc),
    .alloc_rat_i   (w_snap_rat),
    .free_i        (ckpt_free_i && !flush_i),
    .truncate_i    (restore_i && !flush_i),
    .truncate_id_i (restore_id_i),
    .clear_i       (flush_i),
    .read_id_i     (restore_id_i),
    .read_rat_o    (w_restore_rat),
    .full_o        (w_full),
    .empty_o       (w_empty),
    .tail_id_o     (ckpt_id_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spec <= rat_reset_value();
      r_arch <= rat_reset_value();
    end else begin
      r_arch <= w_arch_n;
      if (flush_i) begin
        r_spec <= w_arch_n;
      end else if (restore_i) begin
        r_spec <= w_restore_rat;
      end else if (w_ready) begin
        r_spec <= w_stage[RENAME_WIDTH];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rename_map_table.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rename_map_table : directed + random checks against a behavioural model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_rename_map_table;

  localparam int RW  = 2;
  localparam int CMW = 2;
  localparam int PW  = 6;
  localparam int NCK = 4;
  localparam int CKW = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [RW-1:0]        rename_valid_i;
  logic [RW-1:0][4:0]   src0_i;
  logic [RW-1:0][4:0]   src1_i;
  logic [RW-1:0]        dest_valid_i;
  logic [RW-1:0][4:0]   dest_i;
  logic [RW-1:0][PW-1:0] preg_i;
  logic [RW-1:0]        ckpt_req_i;
  logic                 ready_o;
  logic [RW-1:0][PW-1:0] psrc0_o;
  logic [RW-1:0][PW-1:0] psrc1_o;
  logic [RW-1:0][PW-1:0] ppdst_o;
  logic [CKW-1:0]       ckpt_id_o;
  logic                 ckpt_free_i;
  logic                 restore_i;
  logic [CKW-1:0]       restore_id_i;
  logic [CMW-1:0]       commit_valid_i;
  logic [CMW-1:0][4:0]  commit_dest_i;
  logic [CMW-1:0][PW-1:0] commit_preg_i;
  logic                 flush_i;
  logic [31:0][PW-1:0]  arch_rat_o;

  always #5 clk = ~clk;

  rename_map_table dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rename_valid_i (rename_valid_i),
    .src0_i         (src0_i),
    .src1_i         (src1_i),
    .dest_valid_i   (dest_valid_i),
    .dest_i         (dest_i),
    .preg_i         (preg_i),
    .ckpt_req_i     (ckpt_req_i),
    .ready_o        (ready_o),
    .psrc0_o        (psrc0_o),
    .psrc1_o        (psrc1_o),
    .ppdst_o        (ppdst_o),
    .ckpt_id_o      (ckpt_id_o),
    .ckpt_free_i    (ckpt_free_i),
    .restore_i      (restore_i),
    .restore_id_i   (restore_id_i),
    .commit_valid_i (commit_valid_i),
    .commit_dest_i  (commit_dest_i),
    .commit_preg_i  (commit_preg_i),
    .flush_i        (flush_i),
    .arch_rat_o     (arch_rat_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain arrays, snapshot ring tracked by head + count
  int m_spec [32];
  int m_arch [32];
  int m_snap [NCK][32];
  int m_head;
  int m_cnt;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_spec[r] = r;
      m_arch[r] = r;
    end
    m_head = 0;
    m_cnt  = 0;
  endtask

  task automatic clear_inputs();
    rename_valid_i = '0; src0_i = '0; src1_i = '0; dest_valid_i = '0;
    dest_i = '0; preg_i = '0; ckpt_req_i = '0; ckpt_free_i = 1'b0;
    restore_i = 1'b0; restore_id_i = '0; commit_valid_i = '0;
    commit_dest_i = '0; commit_preg_i = '0; flush_i = 1'b0;
  endtask

  function automatic int m_lookup(input int i, input logic [4:0] r);
    int v;
    if (r == 5'd0) return 0;
    v = m_spec[r];
    for (int j = 0; j < i; j++) begin
      if (dest_valid_i[j] && dest_i[j] == r) v = int'(preg_i[j]);
    end
    return v;
  endfunction

  function automatic bit m_ready();
    return !((|ckpt_req_i) && m_cnt == NCK) && !restore_i && !flush_i;
  endfunction

  task automatic check_outputs();
    check_eq("ready", 32'(ready_o), 32'(m_ready()));
    for (int i = 0; i < RW; i++) begin
      check_eq("psrc0", 32'(psrc0_o[i]), m_lookup(i, src0_i[i]));
      check_eq("psrc1", 32'(psrc1_o[i]), m_lookup(i, src1_i[i]));
      check_eq("ppdst", 32'(ppdst_o[i]), m_lookup(i, dest_i[i]));
    end
    if (|ckpt_req_i) check_eq("ckpt_id", 32'(ckpt_id_o), (m_head + m_cnt) % NCK);
    for (int r = 0; r < 32; r++) begin
      check_eq("arch_rat", 32'(arch_rat_o[r]), m_arch[r]);
    end
  endtask

  task automatic model_update();
    int  arch_n [32];
    int  cnt0;
    bit  rdy;
    cnt0   = m_cnt;
    rdy    = m_ready();
    arch_n = m_arch;
    for (int c = 0; c < CMW; c++) begin
      if (commit_valid_i[c] && commit_dest_i[c] != 5'd0) arch_n[commit_dest_i[c]] = int'(commit_preg_i[c]);
    end
    if (flush_i) begin
      m_spec = arch_n;
      m_cnt  = 0;
    end else begin
      if (restore_i) begin
        m_spec = m_snap[restore_id_i];
        m_cnt  = (int'(restore_id_i) - m_head + NCK) % NCK;
      end else if (rdy) begin
        for (int i = 0; i < RW; i++) begin
          if (rename_valid_i[i] && dest_valid_i[i] && dest_i[i] != 5'd0) m_spec[dest_i[i]] = int'(preg_i[i]);
          if (ckpt_req_i[i]) begin
            m_snap[(m_head + m_cnt) % NCK] = m_spec;
            m_cnt++;
          end
        end
      end
      if (ckpt_free_i && cnt0 > 0) begin
        m_head = (m_head + 1) % NCK;
        m_cnt--;
      end
    end
    m_arch = arch_n;
  endtask

  // Inputs are driven at negedge; outputs sampled 1ns later, model steps at posedge
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    int k;
    int off;
    clear_inputs();
    for (int i = 0; i < RW; i++) begin
      rename_valid_i[i] = ($urandom_range(0, 3) != 0);
      dest_valid_i[i]   = rename_valid_i[i] & 1'($urandom_range(0, 1));
      dest_i[i]         = 5'($urandom_range(0, 7));
      src0_i[i]         = 5'($urandom_range(0, 7));
      src1_i[i]         = 5'($urandom_range(0, 31));
      preg_i[i]         = PW'($urandom_range(0, 63));
    end
    for (int c = 0; c < CMW; c++) begin
      commit_valid_i[c] = 1'($urandom_range(0, 1));
      commit_dest_i[c]  = 5'($urandom_range(0, 7));
      commit_preg_i[c]  = PW'($urandom_range(0, 63));
    end
    if ($urandom_range(0, 2) == 0) begin
      k = $urandom_range(0, RW - 1);
      ckpt_req_i[k]     = 1'b1;
      rename_valid_i[k] = 1'b1;
    end
    if (m_cnt > 0 && $urandom_range(0, 3) == 0) ckpt_free_i = 1'b1;
    if (m_cnt > 0 && $urandom_range(0, 9) == 0) begin
      off          = $urandom_range(0, m_cnt - 1);
      restore_i    = 1'b1;
      restore_id_i = CKW'((m_head + off) % NCK);
      if (off == 0) ckpt_free_i = 1'b0;
    end
    if ($urandom_range(0, 19) == 0) flush_i = 1'b1;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    src0_i[0] = 5'd5;
    #1;
    check_eq("reset_psrc0", 32'(psrc0_o[0]), 5);
    check_eq("reset_arch7", 32'(arch_rat_o[7]), 7);
    check_eq("reset_ready", 32'(ready_o), 1);
    check_eq("reset_ckpt_id", 32'(ckpt_id_o), 0);
    step();

    // Intra-group bypass and WAW
    clear_inputs();
    rename_valid_i = 2'b11; dest_valid_i = 2'b11;
    dest_i[0] = 5'd3; preg_i[0] = 6'd40;
    dest_i[1] = 5'd3; preg_i[1] = 6'd41;
    src0_i[1] = 5'd3;
    #1;
    check_eq("bypass_psrc0", 32'(psrc0_o[1]), 40);
    check_eq("bypass_ppdst", 32'(ppdst_o[1]), 40);
    step();
    clear_inputs();
    src0_i[0] = 5'd3;
    #1;
    check_eq("waw_r3", 32'(psrc0_o[0]), 41);
    step();

    // Checkpoint then restore
    clear_inputs();
    rename_valid_i = 2'b11; dest_valid_i = 2'b11; ckpt_req_i = 2'b01;
    dest_i[0] = 5'd4; preg_i[0] = 6'd50;
    dest_i[1] = 5'd4; preg_i[1] = 6'd51;
    #1;
    check_eq("ckpt_id_first", 32'(ckpt_id_o), 0);
    step();
    clear_inputs();
    restore_i = 1'b1; restore_id_i = 2'd0;
    #1;
    check_eq("restore_ready", 32'(ready_o), 0);
    step();
    clear_inputs();
    src0_i[0] = 5'd4;
    #1;
    check_eq("restore_r4", 32'(psrc0_o[0]), 50);
    check_eq("restore_empty_tail", 32'(ckpt_id_o), 0);
    step();

    // Fill the queue, then a fifth request stalls
    for (int n = 0; n < 4; n++) begin
      clear_inputs();
      rename_valid_i = 2'b01; dest_valid_i = 2'b01; ckpt_req_i = 2'b01;
      dest_i[0] = 5'd9; preg_i[0] = PW'(20 + n);
      #1;
      check_eq("fill_ckpt_id", 32'(ckpt_id_o), 32'(n));
      step();
    end
    clear_inputs();
    rename_valid_i = 2'b01; dest_valid_i = 2'b01; ckpt_req_i = 2'b01;
    dest_i[0] = 5'd9; preg_i[0] = 6'd63;
    #1;
    check_eq("full_ready", 32'(ready_o), 0);
    step();
    clear_inputs();
    ckpt_req_i = 2'b01; rename_valid_i = 2'b01; ckpt_free_i = 1'b1;
    src0_i[0] = 5'd9;
    #1;
    check_eq("full_r9_unchanged", 32'(psrc0_o[0]), 23);
    check_eq("full_free_same_cycle", 32'(ready_o), 0);
    step();
    clear_inputs();
    ckpt_req_i = 2'b01; rename_valid_i = 2'b01;
    #1;
    check_eq("after_free_ready", 32'(ready_o), 1);
    check_eq("after_free_wrap", 32'(ckpt_id_o), 0);
    step();

    // Flush with a same-cycle commit
    clear_inputs();
    flush_i = 1'b1; commit_valid_i = 2'b01;
    commit_dest_i[0] = 5'd6; commit_preg_i[0] = 6'd60;
    step();
    clear_inputs();
    src0_i[0] = 5'd6; ckpt_req_i = 2'b01; rename_valid_i = 2'b01;
    #1;
    check_eq("flush_r6", 32'(psrc0_o[0]), 60);
    check_eq("flush_arch6", 32'(arch_rat_o[6]), 60);
    check_eq("flush_empty_ready", 32'(ready_o), 1);
    check_eq("flush_empty_tail", 32'(ckpt_id_o), 1);
    step();

    // r0 is never remapped
    clear_inputs();
    rename_valid_i = 2'b11; dest_valid_i = 2'b01;
    dest_i[0] = 5'd0; preg_i[0] = 6'd33; src0_i[1] = 5'd0;
    commit_valid_i = 2'b01; commit_dest_i[0] = 5'd0; commit_preg_i[0] = 6'd34;
    #1;
    check_eq("r0_bypass", 32'(psrc0_o[1]), 0);
    step();
    clear_inputs();
    #1;
    check_eq("r0_lookup", 32'(psrc0_o[0]), 0);
    check_eq("r0_arch", 32'(arch_rat_o[0]), 0);
    step();

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      rand_inputs();
      step();
    end

    // Asynchronous reset mid-operation
    clear_inputs();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("midrst_arch5", 32'(arch_rat_o[5]), 5);
    check_eq("midrst_ckpt_id", 32'(ckpt_id_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int n = 0; n < 200; n++) begin
      rand_inputs();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rename_map_table.md
# rename_map_table

Speculative register alias table with branch checkpoints and a committed (architectural) shadow table. Each cycle it renames up to `RENAME_WIDTH` instructions, with intra-group RAW/WAW bypass, and snapshots the map for branches. It restores a snapshot on mispredict, rebuilds from the architectural table on a full flush, and retires up to `COMMIT_WIDTH` mappings into the architectural table. It sits between decode and dispatch; the ROB drives its commit, restore and flush inputs.

## Interface
- `PHY_REG_NUM`, 64: physical registers; must be ≥32. `PW = $clog2(PHY_REG_NUM)`.
- `RENAME_WIDTH`, 2: rename ports (RW).
- `COMMIT_WIDTH`, 2: commit ports (CMW).
- `CKPT_NUM`, 4: checkpoint slots; power of 2. `CKW = $clog2(CKPT_NUM)`.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rename_valid_i` in RW: instruction i present.
- `src0_i`, `src1_i` in RW×5: logical sources.
- `dest_valid_i` in RW: instruction writes a destination.
- `dest_i` in RW×5: logical destination.
- `preg_i` in RW×PW: newly allocated physical register.
- `ckpt_req_i` in RW: instruction i is a branch that needs a snapshot. At most one bit is set.
- `ready_o` out 1: rename group accepted this cycle.
- `psrc0_o`, `psrc1_o` out RW×PW: physical sources.
- `ppdst_o` out RW×PW: previous mapping of `dest_i`, which the ROB frees at commit.
- `ckpt_id_o` out CKW: slot allocated to the requesting branch.
- `ckpt_free_i` in 1: release the oldest checkpoint when its branch resolves correctly.
- `restore_i` in 1, `restore_id_i` in CKW: mispredict; roll back to that slot.
- `commit_valid_i` in CMW, `commit_dest_i` in CMW×5, `commit_preg_i` in CMW×PW: retirements.
- `flush_i` in 1: exception/ertn; rebuild the speculative map from the architectural map.
- `arch_rat_o` out 32×PW: registered architectural table.

## Operation
- **Reset:**
  - Both tables map r→r.
  - Checkpoint queue is empty (head = tail = 0, wrap bits 0).
  - `ready_o` is 1. `ckpt_id_o` is 0.
- **Register r0:**
  - Writes to logical register 0 are suppressed on both the rename and commit paths.
  - Lookups of r0 always return 0.
- **Lookup:**
  - `psrcX_o[i]` is the current table entry, overridden by the highest j<i with `dest_valid_i[j]` and `dest_i[j]`==src. The bypass value is `preg_i[j]`.
  - `ppdst_o[i]` uses the same rule applied to `dest_i[i]`.
- **Write (WAW):** for the same dest, the highest index wins. Writes happen only when `rename_valid_i & dest_valid_i & ready_o`.
- **Checkpoint allocation:**
  - When `ckpt_req_i[k]` is set and the group is accepted, slot `tail` captures the table with the writes of instructions 0..k applied.
  - `ckpt_id_o` = `tail`. Then `tail++` with wrap.
- **Stall:** `ready_o` = !(`|ckpt_req_i` && queue full) && !`restore_i` && !`flush_i`. A stalled group writes nothing and allocates nothing.
- **Free:** `ckpt_free_i` pops the head (`head++`). Free while empty is ignored (assertion in sim).
- **Restore:**
  - The table loads slot `restore_id_i`.
  - `tail` <= `restore_id_i`, which releases that slot and every younger one.
  - A simultaneous free still advances `head`. If `restore_id_i`==`head`, the queue becomes empty.
- **Flush:**
  - The table loads `arch_rat_n`, i.e. the architectural table including this cycle's commits.
  - The queue is emptied (head = tail).
- **Priority:** flush > restore > rename write. Free is applied independently, except under flush.
- **Commit:** architectural writes use the same WAW rule (highest port wins). They are independent of flush and restore.

## Timing
- Lookups and `ckpt_id_o` are combinational from registered state and the inputs.
- Table, snapshot, arch table and pointer updates take effect at the next `posedge clk`.
- After a restore or flush, the first accepted rename is one cycle later and sees the restored map.
- Full/empty: 4 allocations with no frees make the queue full. A 5th request drops `ready_o`. A same-cycle free does not lift the stall; `ready_o` is computed on the registered count.
- Asserting `rst_n` low mid-operation clears all state immediately, including pending snapshots.

## Structure
- `rat_pkg`: `preg_t` (PW bits), `ckpt_id_t`, `rat_t` (32×`preg_t`), and function `rat_reset_value()`.
- Sub-module `rat_ckpt_queue`:
  - Circular head/tail with wrap bit; snapshot storage `CKPT_NUM`×`rat_t`.
  - Ports: alloc, free, truncate-to-id, clear; outputs full, empty, tail_id.
- Top level contains the lookup bypass, WAW masking, both tables and the priority muxing.

## Test plan
- **Reset:** `src0_i`=5 → `psrc0_o`=5; `arch_rat_o[7]`=7.
- **Bypass and WAW:**
  - Stimulus: i0 dest 3→p40, i1 dest 3→p41, i1 src0=3.
  - Required: `psrc0_o[1]`=40 and `ppdst_o[1]`=40.
  - Next cycle a lookup of r3 returns 41.
- **Checkpoint then restore:**
  - Stimulus: i0 dest 4→p50 with `ckpt_req_i[0]`; i1 dest 4→p51. Then restore that id.
  - Required: r4 lookup returns 50, the queue is empty, and `ready_o` was 0 during the restore cycle.
- **Queue full:**
  - 4 checkpoints with no free → 5th request sees `ready_o`=0 and the table is unchanged.
  - `ckpt_free_i` → next cycle `ready_o`=1 and `ckpt_id_o` wraps to 0.
- **Flush with commit:**
  - Stimulus: commit r6→p60 in the same cycle as `flush_i`.
  - Required: next cycle r6 lookup returns 60, `arch_rat_o[6]`=60, and the queue is empty.
- **r0:** dest 0→p33 and commit r0→p34 → the r0 lookup and `arch_rat_o[0]` stay 0.
